tx_serial_7e2: RTL and testbench

- Asynchronous serial transmitter: 7 data bits, parity, 2 stop bits, LSB first.
- Sits directly downstream of the serial output control unit and its character mux.
- Takes the selected ASCII character (hundreds, tens or units digit, or '#') and shifts it onto the line.
- Its pronto pulse drives the control unit's serial_enviado input.

---
 rtl/tx_serial_7e2.sv | 126 ++++++++++++
 tb/tb_tx_serial_7e2.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serial_7e2.sv
// tx_serial_7e2: asynchronous serial transmitter, 7 data bits, parity, 2 stop bits, LSB first.
// A frame is start(0), d0..d6, parity, stop(1), stop(1), and each bit lasts M clocks.
// A one-cycle FINAL state raises pronto and then returns to IDLE.
module tx_serial_7e2 #(
    parameter int M        = 434,
    parameter int PARIDADE = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        IDLE     = 4'b0000,
        START    = 4'b0001,
        DADOS    = 4'b0010,
        PARIDADE_ST = 4'b0011,
        STOP1    = 4'b0100,
        STOP2    = 4'b0101,
        FINAL    = 4'b0110
    } state_t;

    localparam logic [11:0] TICK_MAX = 12'(M - 1);
    localparam logic        PAR_ODD  = (PARIDADE != 0);

    state_t      state;
    state_t      next_state;
    logic [11:0] tick_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_reg;
    logic        parity_bit;
    logic        transmitting;
    logic        bit_done;

    // The tick counter only moves while a bit is on the line, so bit_done marks the last clock of a bit.
    assign transmitting = (state == START) || (state == DADOS) || (state == PARIDADE_ST) ||
                          (state == STOP1) || (state == STOP2);
    assign bit_done     = transmitting && (tick_cnt == TICK_MAX);
    assign db_estado    = state;

    // State register; a low reset returns to IDLE at once, even in the middle of a frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; every bit state advances on its last tick, and unused codes fall back to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:        next_state = partida ? START : IDLE;
            START:       next_state = bit_done ? DADOS : START;
            DADOS:       next_state = (bit_done && (bit_cnt == 3'd6)) ? PARIDADE_ST : DADOS;
            PARIDADE_ST: next_state = bit_done ? STOP1 : PARIDADE_ST;
            STOP1:       next_state = bit_done ? STOP2 : STOP1;
            STOP2:       next_state = bit_done ? FINAL : STOP2;
            FINAL:       next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Datapath: bit timing, the data shifter, the data bit count, and the parity latched with the character.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (transmitting) begin
                tick_cnt <= bit_done ? 12'd0 : tick_cnt + 12'd1;
            end else begin
                tick_cnt <= '0;
            end

            if ((state == IDLE) && partida) begin
                shift_reg  <= dados_ascii;
                parity_bit <= (^dados_ascii) ^ PAR_ODD;
                bit_cnt    <= '0;
            end else if ((state == DADOS) && bit_done) begin
                shift_reg <= {1'b0, shift_reg[6:1]};
                bit_cnt   <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

    // Output decode from registered state only, so input changes never reach the line combinationally.
    always_comb begin
        saida_serial = 1'b1;
        pronto       = 1'b0;
        ocupado      = 1'b0;
        case (state)
            START: begin
                saida_serial = 1'b0;
                ocupado      = 1'b1;
            end
            DADOS: begin
                saida_serial = shift_reg[0];
                ocupado      = 1'b1;
            end
            PARIDADE_ST: begin
                saida_serial = parity_bit;
                ocupado      = 1'b1;
            end
            STOP1, STOP2: begin
                ocupado = 1'b1;
            end
            FINAL: begin
                pronto  = 1'b1;
                ocupado = 1'b1;
            end
            default: begin
                saida_serial = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_serial_7e2.sv
// tb_tx_serial_7e2: bench for tx_serial_7e2 with M=4, covering even (dut_even) and odd (dut_odd) parity.
// Expected frames are hand-built 11-bit words in which bit i is the line level during bit period i.
module tb_tx_serial_7e2;

    localparam int MT = 4;

    logic       clock;
    logic       reset;
    logic       partida_e;
    logic       partida_o;
    logic [6:0] dados;
    logic       line_e, pronto_e, ocupado_e;
    logic       line_o, pronto_o, ocupado_o;
    logic [3:0] estado_e, estado_o;

    logic       sel_odd;
    logic       line_sel, pronto_sel, ocupado_sel;
    logic [3:0] estado_sel;

    int checks;
    int failures;

    logic [10:0] exp_q[$];

    typedef struct {
        logic        odd;
        logic [6:0]  ch;
        logic [10:0] frame;
        string       name;
    } vec_t;

    vec_t vecs[6];

    localparam logic [10:0] FRAME_35 = 11'b110_0110_1010;
    localparam logic [10:0] FRAME_30 = 11'b110_0110_0000;
    localparam logic [10:0] FRAME_32 = 11'b111_0110_0100;

    tx_serial_7e2 #(.M(MT), .PARIDADE(0)) dut_even (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida_e),
        .dados_ascii  (dados),
        .saida_serial (line_e),
        .pronto       (pronto_e),
        .ocupado      (ocupado_e),
        .db_estado    (estado_e)
    );

    tx_serial_7e2 #(.M(MT), .PARIDADE(1)) dut_odd (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida_o),
        .dados_ascii  (dados),
        .saida_serial (line_o),
        .pronto       (pronto_o),
        .ocupado      (ocupado_o),
        .db_estado    (estado_o)
    );

    assign line_sel    = sel_odd ? line_o    : line_e;
    assign pronto_sel  = sel_odd ? pronto_o  : pronto_e;
    assign ocupado_sel = sel_odd ? ocupado_o : ocupado_e;
    assign estado_sel  = sel_odd ? estado_o  : estado_e;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected state for sample j cycles after the accepting edge.
    function automatic logic [3:0] expState(input int j);
        int b;
        b = j / MT;
        if (b == 0) return 4'd1;
        if (b <= 7) return 4'd2;
        if (b == 8) return 4'd3;
        if (b == 9) return 4'd4;
        if (b == 10) return 4'd5;
        if (j == 11 * MT) return 4'd6;
        return 4'd0;
    endfunction

    // Called at a negedge; returns at the sample point just after the accepting edge.
    task automatic applyStimulus(input logic [6:0] ch, input logic [10:0] frame);
        exp_q.push_back(frame);
        dados = ch;
        if (sel_odd) partida_o = 1'b1;
        else         partida_e = 1'b1;
        @(negedge clock);
        partida_o = 1'b0;
        partida_e = 1'b0;
    endtask

    // Pops one frame and checks every cycle from the start bit through the first idle cycle.
    task automatic checkFrame(input string name);
        logic [10:0] frame;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, got 0, expected 1 entry", name);
            return;
        end
        frame = exp_q.pop_front();
        for (int j = 0; j < 11 * MT; j++) begin
            checkOutput($sformatf("%s line c%0d", name, j), {10'd0, line_sel}, {10'd0, frame[j / MT]});
            checkOutput($sformatf("%s ocupado c%0d", name, j), {10'd0, ocupado_sel}, 11'd1);
            checkOutput($sformatf("%s pronto c%0d", name, j), {10'd0, pronto_sel}, 11'd0);
            checkOutput($sformatf("%s estado c%0d", name, j), {7'd0, estado_sel}, {7'd0, expState(j)});
            @(negedge clock);
        end
        checkOutput({name, " final pronto"}, {10'd0, pronto_sel}, 11'd1);
        checkOutput({name, " final ocupado"}, {10'd0, ocupado_sel}, 11'd1);
        checkOutput({name, " final line"}, {10'd0, line_sel}, 11'd1);
        checkOutput({name, " final estado"}, {7'd0, estado_sel}, 11'd6);
        @(negedge clock);
        checkOutput({name, " idle pronto"}, {10'd0, pronto_sel}, 11'd0);
        checkOutput({name, " idle ocupado"}, {10'd0, ocupado_sel}, 11'd0);
        checkOutput({name, " idle line"}, {10'd0, line_sel}, 11'd1);
        checkOutput({name, " idle estado"}, {7'd0, estado_sel}, 11'd0);
    endtask

    task automatic checkIdle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checkOutput($sformatf("%s line i%0d", name, i), {10'd0, line_sel}, 11'd1);
            checkOutput($sformatf("%s ocupado i%0d", name, i), {10'd0, ocupado_sel}, 11'd0);
            checkOutput($sformatf("%s pronto i%0d", name, i), {10'd0, pronto_sel}, 11'd0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sel_odd   = 1'b0;
        reset     = 1'b0;
        partida_e = 1'b0;
        partida_o = 1'b0;
        dados     = 7'h00;

        vecs[0] = '{odd: 1'b0, ch: 7'h31, frame: 11'b111_0110_0010, name: "even 0x31"};
        vecs[1] = '{odd: 1'b1, ch: 7'h23, frame: 11'b110_0100_0110, name: "odd 0x23"};
        vecs[2] = '{odd: 1'b0, ch: 7'h00, frame: 11'b110_0000_0000, name: "even 0x00"};
        vecs[3] = '{odd: 1'b0, ch: 7'h7F, frame: 11'b111_1111_1110, name: "even 0x7F"};
        vecs[4] = '{odd: 1'b1, ch: 7'h7F, frame: 11'b110_1111_1110, name: "odd 0x7F"};
        vecs[5] = '{odd: 1'b1, ch: 7'h00, frame: 11'b111_0000_0000, name: "odd 0x00"};

        // Reset held for 3 cycles, then released between edges.
        repeat (3) @(negedge clock);
        checkOutput("in reset line", {10'd0, line_e}, 11'd1);
        checkOutput("in reset ocupado", {10'd0, ocupado_e}, 11'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset line", {10'd0, line_e}, 11'd1);
        checkOutput("reset pronto", {10'd0, pronto_e}, 11'd0);
        checkOutput("reset ocupado", {10'd0, ocupado_e}, 11'd0);
        checkOutput("reset estado", {7'd0, estado_e}, 11'd0);
        checkOutput("reset odd line", {10'd0, line_o}, 11'd1);
        checkOutput("reset odd estado", {7'd0, estado_o}, 11'd0);

        // Single frames from the vector table.
        for (int v = 0; v < 6; v++) begin
            sel_odd = vecs[v].odd;
            applyStimulus(vecs[v].ch, vecs[v].frame);
            checkFrame(vecs[v].name);
            @(negedge clock);
        end
        sel_odd = 1'b0;

        // Data change and partida pulses mid-frame and during FINAL must not disturb anything.
        applyStimulus(7'h35, FRAME_35);
        fork
            checkFrame("mid-frame 0x35");
            begin
                repeat (9) @(negedge clock);
                dados     = 7'h7F;
                partida_e = 1'b1;
                @(negedge clock);
                partida_e = 1'b0;
                repeat (33) @(negedge clock);
                partida_e = 1'b1;
                @(negedge clock);
                partida_e = 1'b0;
            end
        join
        checkIdle("no second frame", 8);

        // partida held high: two frames with one idle cycle between them.
        dados = 7'h30;
        exp_q.push_back(FRAME_30);
        exp_q.push_back(FRAME_30);
        partida_e = 1'b1;
        @(negedge clock);
        checkFrame("b2b first");
        @(negedge clock);
        partida_e = 1'b0;
        checkFrame("b2b second");
        checkIdle("after b2b", 4);

        // Reset during data bit 3, then a clean 0x32 frame.
        dados     = 7'h35;
        partida_e = 1'b1;
        @(negedge clock);
        partida_e = 1'b0;
        for (int j = 0; j < 17; j++) begin
            checkOutput($sformatf("pre-reset line c%0d", j), {10'd0, line_e}, {10'd0, FRAME_35[j / MT]});
            @(negedge clock);
        end
        checkOutput("pre-reset estado", {7'd0, estado_e}, 11'd2);
        reset = 1'b0;
        #1;
        checkOutput("async reset line", {10'd0, line_e}, 11'd1);
        checkOutput("async reset ocupado", {10'd0, ocupado_e}, 11'd0);
        checkOutput("async reset pronto", {10'd0, pronto_e}, 11'd0);
        checkOutput("async reset estado", {7'd0, estado_e}, 11'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(7'h32, FRAME_32);
        checkFrame("after reset 0x32");

        checkOutput("scoreboard drained", 11'(exp_q.size()), 11'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
